// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32,
    parameter bit AUTO_DECODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       fmt_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt_out,
    output logic             illegal,
    output logic [TAG_W-1:0] tag_out
);

    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_S     = 3'b001;
    localparam logic [2:0] FMT_B     = 3'b010;
    localparam logic [2:0] FMT_U     = 3'b011;
    localparam logic [2:0] FMT_J     = 3'b100;
    localparam logic [2:0] FMT_Z     = 3'b101;
    localparam logic [2:0] FMT_SHAMT = 3'b110;
    localparam logic [2:0] FMT_ILL   = 3'b111;

    logic [2:0]       fmt_auto;
    logic             shamt5_auto;
    logic [2:0]       fmt_sel;
    logic             shamt5;
    logic [31:0]      raw32;
    logic [XLEN-1:0]  imm_ext;
    logic             ill_sel;

    logic [1:0]       occ_q, occ_d;
    logic             in_ready_q, in_ready_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_fmt_q, out_fmt_d;
    logic             out_ill_q, out_ill_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_fmt_q, skid_fmt_d;
    logic             skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic             in_fire;
    logic             out_fire;

    // Derive the format from opcode/funct3; OP-IMM-32 shifts only exist on RV64 and keep a 5-bit shamt
    always_comb begin
        fmt_auto    = FMT_ILL;
        shamt5_auto = 1'b0;
        case (instr[6:0])
            7'b0000011, 7'b1100111: fmt_auto = FMT_I;
            7'b0010011: fmt_auto = (instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
            7'b0011011: begin
                if (XLEN == 64) begin
                    fmt_auto    = (instr[13:12] == 2'b01) ? FMT_SHAMT : FMT_I;
                    shamt5_auto = 1'b1;
                end
            end
            7'b0100011: fmt_auto = FMT_S;
            7'b1100011: fmt_auto = FMT_B;
            7'b0110111, 7'b0010111: fmt_auto = FMT_U;
            7'b1101111: fmt_auto = FMT_J;
            7'b1110011: fmt_auto = instr[14] ? FMT_Z : FMT_I;
            default: fmt_auto = FMT_ILL;
        endcase
        fmt_sel = AUTO_DECODE ? fmt_auto : fmt_in;
        shamt5  = AUTO_DECODE ? shamt5_auto : 1'b0;
    end

    // Build the 32-bit immediate; bit 31 is the sign for every sign-extended format and 0 otherwise
    always_comb begin
        raw32 = 32'b0;
        case (fmt_sel)
            FMT_I: raw32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: raw32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: raw32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: raw32 = {instr[31:12], 12'b0};
            FMT_J: raw32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_Z: raw32 = {27'b0, instr[19:15]};
            FMT_SHAMT: begin
                if ((XLEN == 64) && !shamt5) raw32 = {26'b0, instr[25:20]};
                else                         raw32 = {27'b0, instr[24:20]};
            end
            default: raw32 = 32'b0;
        endcase
        ill_sel = (fmt_sel == FMT_ILL);
    end

    if (XLEN > 32) begin : g_wide
        assign imm_ext = {{(XLEN-32){raw32[31]}}, raw32};
    end else begin : g_narrow
        assign imm_ext = raw32;
    end

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = (occ_q != 2'd0) && out_ready;

    // Occupancy next-state: output stage first, overflow into skid, skid refills output on drain
    always_comb begin
        occ_d      = occ_q;
        out_imm_d  = out_imm_q;
        out_fmt_d  = out_fmt_q;
        out_ill_d  = out_ill_q;
        out_tag_d  = out_tag_q;
        skid_imm_d = skid_imm_q;
        skid_fmt_d = skid_fmt_q;
        skid_ill_d = skid_ill_q;
        skid_tag_d = skid_tag_q;
        case (occ_q)
            2'd0: begin
                if (in_fire) begin
                    out_imm_d = imm_ext;
                    out_fmt_d = fmt_sel;
                    out_ill_d = ill_sel;
                    out_tag_d = tag_in;
                    occ_d     = 2'd1;
                end
            end
            2'd1: begin
                if (in_fire && out_fire) begin
                    out_imm_d = imm_ext;
                    out_fmt_d = fmt_sel;
                    out_ill_d = ill_sel;
                    out_tag_d = tag_in;
                end else if (in_fire) begin
                    skid_imm_d = imm_ext;
                    skid_fmt_d = fmt_sel;
                    skid_ill_d = ill_sel;
                    skid_tag_d = tag_in;
                    occ_d      = 2'd2;
                end else if (out_fire) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (out_fire) begin
                    out_imm_d = skid_imm_q;
                    out_fmt_d = skid_fmt_q;
                    out_ill_d = skid_ill_q;
                    out_tag_d = skid_tag_q;
                    occ_d     = 2'd1;
                end
            end
            default: occ_d = 2'd0;
        endcase
        in_ready_d = (occ_d != 2'd2);
    end

    // State register; reset discards in-flight entries and clears the visible outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= 2'd0;
            in_ready_q <= 1'b1;
            out_imm_q  <= '0;
            out_fmt_q  <= 3'b000;
            out_ill_q  <= 1'b0;
            out_tag_q  <= '0;
            skid_imm_q <= '0;
            skid_fmt_q <= 3'b000;
            skid_ill_q <= 1'b0;
            skid_tag_q <= '0;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            out_imm_q  <= out_imm_d;
            out_fmt_q  <= out_fmt_d;
            out_ill_q  <= out_ill_d;
            out_tag_q  <= out_tag_d;
            skid_imm_q <= skid_imm_d;
            skid_fmt_q <= skid_fmt_d;
            skid_ill_q <= skid_ill_d;
            skid_tag_q <= skid_tag_d;
        end
    end

    // Outputs straight from registers so neither handshake direction has a combinational path
    always_comb begin
        out_valid = (occ_q != 2'd0);
        in_ready  = in_ready_q;
        imm       = out_imm_q;
        fmt_out   = out_fmt_q;
        illegal   = out_ill_q;
        tag_out   = out_tag_q;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [2:0]  fmt_in;
    logic [31:0] tag_in;

    logic        rdy32, ov32, il32;
    logic [31:0] imm32, tg32;
    logic [2:0]  fo32;
    logic        rdy64, ov64, il64;
    logic [63:0] imm64;
    logic [31:0] tg64;
    logic [2:0]  fo64;
    logic        rdym, ovm, ilm;
    logic [31:0] immm, tgm;
    logic [2:0]  fom;

    int vectors = 0;
    int errs    = 0;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  fs;
        logic [31:0] tg;
    } in_t;

    typedef struct {
        logic [31:0] i32; logic [2:0] f32; logic l32; logic [31:0] t32;
        logic [63:0] i64; logic [2:0] f64; logic l64; logic [31:0] t64;
        logic [31:0] im;  logic [2:0] fm;  logic lm;  logic [31:0] tm;
    } out_t;

    in_t  exp_q[$];
    out_t got_q[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
        .fmt_in(fmt_in), .tag_in(tag_in), .out_valid(ov32), .out_ready(out_ready),
        .imm(imm32), .fmt_out(fo32), .illegal(il32), .tag_out(tg32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .AUTO_DECODE(1'b1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .instr(instr),
        .fmt_in(fmt_in), .tag_in(tag_in), .out_valid(ov64), .out_ready(out_ready),
        .imm(imm64), .fmt_out(fo64), .illegal(il64), .tag_out(tg64));

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .AUTO_DECODE(1'b0)) dutm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdym), .instr(instr),
        .fmt_in(fmt_in), .tag_in(tag_in), .out_valid(ovm), .out_ready(out_ready),
        .imm(immm), .fmt_out(fom), .illegal(ilm), .tag_out(tgm));

    always #5 clk = ~clk;

    // Reference: decode by the opcode table, build the value with signed arithmetic, then truncate
    function automatic void model(input int xlen, input bit autod, input logic [31:0] ins,
                                  input logic [2:0] fsel, output logic [63:0] eimm,
                                  output logic [2:0] efmt, output logic eill);
        longint      v;
        logic [2:0]  f;
        logic [2:0]  f3;
        bit          sh5;
        f3  = ins[14:12];
        sh5 = 1'b0;
        f   = fsel;
        if (autod) begin
            case (ins[6:0])
                7'b0000011, 7'b1100111: f = 3'd0;
                7'b0010011: f = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
                7'b0011011: begin
                    if (xlen == 64) begin
                        f   = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
                        sh5 = 1'b1;
                    end else f = 3'd7;
                end
                7'b0100011: f = 3'd1;
                7'b1100011: f = 3'd2;
                7'b0110111, 7'b0010111: f = 3'd3;
                7'b1101111: f = 3'd4;
                7'b1110011: f = f3[2] ? 3'd5 : 3'd0;
                default: f = 3'd7;
            endcase
        end
        case (f)
            3'd0: v = $signed(ins[31:20]);
            3'd1: v = $signed({ins[31:25], ins[11:7]});
            3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
            3'd3: v = $signed(ins[31:12]) * longint'(4096);
            3'd4: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
            3'd5: v = longint'(ins[19:15]);
            3'd6: v = (xlen == 64 && !sh5) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            default: v = 0;
        endcase
        eimm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
        efmt = f;
        eill = (f == 3'd7);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  r[6:0] = 7'b0000011;
            1:  r[6:0] = 7'b1100111;
            2:  r[6:0] = 7'b0010011;
            3:  r[6:0] = 7'b0011011;
            4:  r[6:0] = 7'b0100011;
            5:  r[6:0] = 7'b1100011;
            6:  r[6:0] = 7'b0110111;
            7:  r[6:0] = 7'b0010111;
            8:  r[6:0] = 7'b1101111;
            9:  r[6:0] = 7'b1110011;
            default: ;
        endcase
        return r;
    endfunction

    // Record the transfers that the next rising edge will perform, then advance one cycle
    task automatic tick();
        in_t  e;
        out_t g;
        if (!rst && in_valid && rdy32) begin
            e.ins = instr; e.fs = fmt_in; e.tg = tag_in;
            exp_q.push_back(e);
        end
        if (!rst && ov32 && out_ready) begin
            g.i32 = imm32; g.f32 = fo32; g.l32 = il32; g.t32 = tg32;
            g.i64 = imm64; g.f64 = fo64; g.l64 = il64; g.t64 = tg64;
            g.im  = immm;  g.fm  = fom;  g.lm  = ilm;  g.tm  = tgm;
            got_q.push_back(g);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; instr = 32'hFFF00093; tag_in = 32'h55;
        tick();
        vectors++;
        if (rdy32 !== 1'b1) begin errs++; $display("FAIL reset_in_ready_during_rst got=%b exp=1", rdy32); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors++;
        if (ov32 !== 1'b0 || ov64 !== 1'b0 || ovm !== 1'b0) begin
            errs++; $display("FAIL reset_out_valid got=%b%b%b exp=000", ov32, ov64, ovm);
        end
        vectors++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1 || rdym !== 1'b1) begin
            errs++; $display("FAIL reset_in_ready got=%b%b%b exp=111", rdy32, rdy64, rdym);
        end
        vectors++;
        if (imm32 !== 32'h0 || imm64 !== 64'h0 || fo32 !== 3'b000 || il32 !== 1'b0 || tg32 !== 32'h0 || tgm !== 32'h0) begin
            errs++; $display("FAIL reset_outputs imm=%h imm64=%h fmt=%0d ill=%b tag=%h exp all zero", imm32, imm64, fo32, il32, tg32);
        end
        clear_q();
    endtask

    task automatic test_single();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFF00093; tag_in = 32'h100; fmt_in = 3'd0;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (ov32 !== 1'b1 || imm32 !== 32'hFFFF_FFFF || fo32 !== 3'b000 || tg32 !== 32'h100) begin
            errs++; $display("FAIL single_addi valid=%b imm=%h fmt=%0d tag=%h exp 1/ffffffff/0/00000100", ov32, imm32, fo32, tg32);
        end
        vectors++;
        if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errs++; $display("FAIL single_addi64 imm=%h exp=ffffffffffffffff", imm64);
        end
        tick();
        vectors++;
        if (ov32 !== 1'b0) begin errs++; $display("FAIL single_drain valid=%b exp=0", ov32); end
        clear_q();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4] = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h300FD073};
        logic [31:0] eim [4] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h1234_5000, 32'h0000_001F};
        logic [2:0]  efm [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
        out_t g;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instr = ins[i]; tag_in = 32'h200 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (got_q.size() != 4) begin errs++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
        for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            vectors++;
            if (g.i32 !== eim[i] || g.f32 !== efm[i] || g.t32 !== 32'h200 + 32'(i)) begin
                errs++; $display("FAIL b2b_%0d imm=%h fmt=%0d tag=%h exp imm=%h fmt=%0d tag=%h",
                                 i, g.i32, g.f32, g.t32, eim[i], efm[i], 32'h200 + 32'(i));
            end
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        logic [31:0] ins [3] = '{32'hFE112E23, 32'hFE000CE3, 32'h123452B7};
        out_t g;
        out_ready = 1'b0;
        in_valid = 1'b1; instr = ins[0]; tag_in = 32'h1;
        tick();
        instr = ins[1]; tag_in = 32'h2;
        tick();
        vectors++;
        if (rdy32 !== 1'b0) begin errs++; $display("FAIL bp_in_ready_full got=%b exp=0", rdy32); end
        instr = ins[2]; tag_in = 32'h3;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (ov32 !== 1'b1 || imm32 !== 32'hFFFF_FFFC || tg32 !== 32'h1 || rdy32 !== 1'b0) begin
                errs++; $display("FAIL bp_hold valid=%b imm=%h tag=%h rdy=%b exp 1/fffffffc/1/0", ov32, imm32, tg32, rdy32);
            end
        end
        vectors++;
        if (exp_q.size() != 2) begin errs++; $display("FAIL bp_accepted got=%0d exp=2", exp_q.size()); end
        out_ready = 1'b1;
        for (int i = 0; i < 12 && exp_q.size() < 3; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && got_q.size() < 3; i++) tick();
        vectors++;
        if (got_q.size() != 3) begin errs++; $display("FAIL bp_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            vectors++;
            if (g.t32 !== 32'(i + 1)) begin errs++; $display("FAIL bp_order_%0d tag=%h exp=%h", i, g.t32, 32'(i + 1)); end
        end
        clear_q();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1;
        instr = $urandom & 32'hFFFF_FF80; fmt_in = 3'b111; tag_in = 32'h77;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (ovm !== 1'b1 || immm !== 32'h0 || ilm !== 1'b1 || fom !== 3'b111) begin
            errs++; $display("FAIL ill_fmt111 valid=%b imm=%h ill=%b fmt=%0d exp 1/0/1/7", ovm, immm, ilm, fom);
        end
        vectors++;
        if (imm32 !== 32'h0 || il32 !== 1'b1 || fo32 !== 3'b111 || il64 !== 1'b1 || imm64 !== 64'h0) begin
            errs++; $display("FAIL ill_opcode0 imm=%h ill=%b fmt=%0d ill64=%b exp 0/1/7/1", imm32, il32, fo32, il64);
        end
        tick();
        clear_q();
    endtask

    task automatic test_xlen64();
        logic [31:0] ins [3] = '{32'hFFF00093, 32'h800002B7, 32'h03F09093};
        logic [63:0] eim [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h3F};
        logic [2:0]  efm [3] = '{3'd0, 3'd3, 3'd6};
        out_t g;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; instr = ins[i]; tag_in = 32'h300 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (got_q.size() != 3) begin errs++; $display("FAIL x64_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            vectors++;
            if (g.i64 !== eim[i] || g.f64 !== efm[i]) begin
                errs++; $display("FAIL x64_%0d imm=%h fmt=%0d exp imm=%h fmt=%0d", i, g.i64, g.f64, eim[i], efm[i]);
            end
            if (i == 2) begin
                vectors++;
                if (g.i32 !== 32'h1F || g.f32 !== 3'd6) begin
                    errs++; $display("FAIL x32_slli imm=%h fmt=%0d exp imm=0000001f fmt=6", g.i32, g.f32);
                end
            end
        end
        clear_q();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'hFE112E23; tag_in = 32'hA1;
        tick();
        instr = 32'hFE000CE3; tag_in = 32'hA2;
        tick();
        vectors++;
        if (rdy32 !== 1'b0) begin errs++; $display("FAIL mid_full in_ready=%b exp=0", rdy32); end
        rst = 1'b1; instr = 32'h123452B7; tag_in = 32'hA3;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        vectors++;
        if (ov32 !== 1'b0 || rdy32 !== 1'b1 || ov64 !== 1'b0 || ovm !== 1'b0) begin
            errs++; $display("FAIL mid_reset valid=%b rdy=%b exp valid=0 rdy=1", ov32, rdy32);
        end
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (got_q.size() != 0) begin errs++; $display("FAIL mid_stale got=%0d results exp=0", got_q.size()); end
        clear_q();
    endtask

    task automatic test_random();
        bit          hold;
        logic [31:0] s_i32, s_t32;
        logic [63:0] s_i64;
        logic [2:0]  s_f32;
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        in_t         e;
        out_t        g;
        int          guard;
        int          n;
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            instr     = rand_instr();
            fmt_in    = 3'($urandom);
            tag_in    = $urandom;
            hold  = ov32 && !out_ready;
            s_i32 = imm32; s_t32 = tg32; s_i64 = imm64; s_f32 = fo32;
            tick();
            if (hold) begin
                vectors++;
                if (ov32 !== 1'b1 || imm32 !== s_i32 || tg32 !== s_t32 || imm64 !== s_i64 || fo32 !== s_f32) begin
                    errs++; $display("FAIL rand_hold cyc=%0d valid=%b imm=%h tag=%h exp imm=%h tag=%h", c, ov32, imm32, tg32, s_i32, s_t32);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while (got_q.size() < exp_q.size() && guard < 20) begin tick(); guard++; end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errs++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            model(32, 1'b1, e.ins, e.fs, e_imm, e_fmt, e_ill);
            vectors++;
            if (g.i32 !== e_imm[31:0] || g.f32 !== e_fmt || g.l32 !== e_ill || g.t32 !== e.tg) begin
                errs++; $display("FAIL rand32 #%0d ins=%h imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b tag=%h",
                                 n, e.ins, g.i32, g.f32, g.l32, g.t32, e_imm[31:0], e_fmt, e_ill, e.tg);
            end
            model(64, 1'b1, e.ins, e.fs, e_imm, e_fmt, e_ill);
            vectors++;
            if (g.i64 !== e_imm || g.f64 !== e_fmt || g.l64 !== e_ill || g.t64 !== e.tg) begin
                errs++; $display("FAIL rand64 #%0d ins=%h imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b tag=%h",
                                 n, e.ins, g.i64, g.f64, g.l64, g.t64, e_imm, e_fmt, e_ill, e.tg);
            end
            model(32, 1'b0, e.ins, e.fs, e_imm, e_fmt, e_ill);
            vectors++;
            if (g.im !== e_imm[31:0] || g.fm !== e_fmt || g.lm !== e_ill || g.tm !== e.tg) begin
                errs++; $display("FAIL randman #%0d ins=%h sel=%0d imm=%h fmt=%0d ill=%b tag=%h exp imm=%h fmt=%0d ill=%b tag=%h",
                                 n, e.ins, e.fs, g.im, g.fm, g.lm, g.tm, e_imm[31:0], e_fmt, e_ill, e.tg);
            end
            n++;
        end
        clear_q();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = 32'h0; fmt_in = 3'd0; tag_in = 32'h0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_xlen64();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
